// File: rtl/idct2_1d_serial.sv
// Serial 1-D inverse DCT-II for N = 4/8/16/32: one coefficient-by-matrix MAC per
// cycle, N*N cycles per vector, samples rounded, shifted and saturated to 16 bits.
module idct2_1d_serial #(
    parameter int SHIFT = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   N_in,
    input  logic [0:511] X_test,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:511] Y
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    localparam logic signed [31:0] RND = 32'sd1 <<< (SHIFT - 1);

    state_t              state_q, state_d;
    logic [0:511]        x_q, x_d;
    logic [0:511]        y_q, y_d;
    logic [1:0]          nsel_q, nsel_d;
    logic [4:0]          n_q, n_d;
    logic [4:0]          k_q, k_d;
    logic signed [31:0]  acc_q, acc_d;
    logic                ov_q, ov_d;

    logic [4:0]          nm1;
    logic [4:0]          krow;
    logic signed [7:0]   coef;
    logic signed [15:0]  xk;
    logic signed [31:0]  prod;
    logic signed [31:0]  sum;
    logic signed [31:0]  shf;
    logic [15:0]         y_val;

    function automatic logic signed [7:0] cv(input logic [4:0] i);
        logic signed [7:0] r;
        case (i)
            5'd1:  r = 8'sd90;  5'd2:  r = 8'sd90;  5'd3:  r = 8'sd90;  5'd4:  r = 8'sd89;
            5'd5:  r = 8'sd88;  5'd6:  r = 8'sd87;  5'd7:  r = 8'sd85;  5'd8:  r = 8'sd83;
            5'd9:  r = 8'sd82;  5'd10: r = 8'sd80;  5'd11: r = 8'sd78;  5'd12: r = 8'sd75;
            5'd13: r = 8'sd73;  5'd14: r = 8'sd70;  5'd15: r = 8'sd67;  5'd16: r = 8'sd64;
            5'd17: r = 8'sd61;  5'd18: r = 8'sd57;  5'd19: r = 8'sd54;  5'd20: r = 8'sd50;
            5'd21: r = 8'sd46;  5'd22: r = 8'sd43;  5'd23: r = 8'sd38;  5'd24: r = 8'sd36;
            5'd25: r = 8'sd31;  5'd26: r = 8'sd25;  5'd27: r = 8'sd22;  5'd28: r = 8'sd18;
            5'd29: r = 8'sd13;  5'd30: r = 8'sd9;   5'd31: r = 8'sd4;
            default: r = 8'sd0;
        endcase
        return r;
    endfunction

    // k*(2n+1) mod 128 never lands on 0/32/64/96 for k in 1..31, so the
    // four quadrant cases below are exhaustive.
    function automatic logic signed [7:0] t32(input logic [4:0] k, input logic [4:0] n);
        logic [6:0]        m;
        logic signed [7:0] r;
        m = 7'({7'd0, k} * {6'd0, n, 1'b1});
        if (k == 5'd0)        r = 8'sd64;
        else if (m < 7'd32)   r = cv(m[4:0]);
        else if (m < 7'd64)   r = -cv(5'(7'd64 - m));
        else if (m < 7'd96)   r = -cv(5'(m - 7'd64));
        else                  r = cv(5'(8'd128 - {1'b0, m}));
        return r;
    endfunction

    assign nm1  = 5'((6'd4 << nsel_q) - 6'd1);
    assign krow = 5'(k_q << (2'd3 - nsel_q));
    assign coef = t32(krow, n_q);
    assign xk   = x_q[{k_q, 4'b0000} +: 16];
    assign prod = 32'(coef) * 32'(xk);
    assign sum  = acc_q + prod;
    assign shf  = (sum + RND) >>> SHIFT;

    always_comb begin
        if (shf > 32'sd32767)       y_val = 16'h7fff;
        else if (shf < -32'sd32768) y_val = 16'h8000;
        else                        y_val = shf[15:0];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        nsel_d  = nsel_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = X_test;
                    nsel_d  = N_in;
                    acc_d   = '0;
                    y_d     = '0;
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == nm1) begin
                    y_d[{n_q, 4'b0000} +: 16] = y_val;
                    acc_d = '0;
                    k_d   = '0;
                    if (n_q == nm1) begin
                        state_d = S_DONE;
                        ov_d    = 1'b1;
                    end else begin
                        n_d = n_q + 5'd1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            nsel_q  <= '0;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            nsel_q  <= nsel_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = ov_q;
    assign Y         = y_q;

endmodule
